// File: rtl/sync_clk_divider.sv
// Glitch-free integer clock divider: clko = clki / (divs+1), built from a
// low-transparent clock-gate latch ORed with a registered stretch term.
`timescale 1ns/1ps

module sync_clk_divider_tlatnca (
  input  logic ck,
  input  logic e,
  output logic eck
);
  logic en_l;

  // NOTE: a deliberate level-sensitive latch; it only follows e while ck is low,
  // so an enable change during the high phase can never chop or create a pulse.
  always_latch begin
    if (!ck) en_l = e;
  end

  assign eck = ck & en_l;
endmodule

module sync_clk_divider_or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module sync_clk_divider #(
  parameter int unsigned    DW = 8,
  parameter logic [DW-1:0]  RV = '0
) (
  input  logic          clki,
  output logic          clko,
  input  logic          rst_,
  input  logic [DW-1:0] divs,
  output logic          plso
);
  logic [DW-1:0] ss;
  logic [DW-1:0] cnt;
  logic          rr;
  logic          fr;
  (* keep = "true" *) logic ovf;
  logic          hovf;
  logic          rr_next;
  logic          gclk;
  logic          rr_fr;

  assign ovf     = (cnt == ss);
  assign hovf    = (cnt == {1'b0, ss[DW-1:1]});
  assign rr_next = (ovf | rr) & ~hovf;

  // NOTE: non-blocking so every clki flop samples the pre-edge cnt/ss/rr values,
  // including ss, which is reloaded on the clko edge in the same time step.
  always_ff @(posedge clki or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
      rr  <= 1'b0;
      fr  <= 1'b0;
    end else begin
      cnt <= (ovf || ss == '0) ? '0 : cnt + 1'b1;
      rr  <= rr_next;
      fr  <= rr_next | ss[0];
    end
  end

  // Divisor is sampled only when clko rises, so a new divs takes effect at a period boundary.
  always_ff @(posedge clko or negedge rst_) begin
    if (!rst_) ss <= RV;
    else       ss <= divs;
  end

  (* dont_touch = "true" *)
  sync_clk_divider_tlatnca u_cg (
    .ck  (clki),
    .e   (ovf),
    .eck (gclk)
  );

  assign rr_fr = rr & fr;

  (* dont_touch = "true" *)
  sync_clk_divider_or2 u_or (
    .a (gclk),
    .b (rr_fr),
    .y (clko)
  );

  assign plso = ovf;
endmodule

// File: tb/tb_sync_clk_divider.sv
// Self-checking bench for sync_clk_divider: period-level waveform model checked
// every clki half-cycle, plus measured clko period/high-time literals.
`timescale 1ns/1ps

module tb_sync_clk_divider;
  localparam int unsigned DW = 8;

  logic          clki = 1'b0;
  logic          rst_ = 1'b1;
  logic [DW-1:0] divs = '0;
  logic          clko;
  logic          plso;

  int checks = 0;
  int errors = 0;

  // Model: divisor in effect, position in period, whether this period carries the stretch.
  bit   model_on = 1'b0;
  int   m_k = 0;
  int   m_p = 0;
  logic m_str = 1'b0;
  logic m_prev_lo = 1'b0;
  logic m_hi = 1'b1;
  logic m_lo = 1'b0;
  logic m_plso = 1'b1;

  time  last_rise = 0;
  time  last_fall = 0;
  int   meas_period = 0;
  int   meas_high = 0;
  int   rise_cnt = 0;
  bit   mon_en = 1'b0;

  sync_clk_divider #(.DW(DW), .RV('0)) dut (
    .clki (clki),
    .clko (clko),
    .rst_ (rst_),
    .divs (divs),
    .plso (plso)
  );

  always #5 clki = ~clki;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_p = 0; m_str = 1'b0; m_prev_lo = 1'b0;
    m_hi = 1'b1; m_lo = 1'b0; m_plso = 1'b1;
  endtask

  // A period of k+1 cycles starts when the previous one ends. clko rises at the start
  // unless it was already held high, and only that rise adopts divs. A period that
  // follows a k>=1 period stays high through position floor(k/2).
  always @(posedge clki) begin
    if (model_on && rst_) begin
      if (m_p == m_k) begin
        m_str = (m_k != 0);
        if (!m_prev_lo) m_k = int'(divs);
        m_p   = 0;
        m_hi  = 1'b1;
        m_lo  = m_str;
      end else begin
        m_p++;
        m_hi = m_str && (m_p <= m_k / 2);
        m_lo = m_hi;
      end
      m_plso    = (m_p == m_k);
      m_prev_lo = m_lo;
    end
  end

  always begin
    @(posedge clki); #2;
    if (model_on) begin
      check("clko_high_phase", 32'(clko), 32'(m_hi));
      check("plso_high_phase", 32'(plso), 32'(m_plso));
    end
    @(negedge clki); #2;
    if (model_on) begin
      check("clko_low_phase", 32'(clko), 32'(m_lo));
      check("plso_low_phase", 32'(plso), 32'(m_plso));
    end
  end

  always @(posedge clko) begin
    meas_period = int'($time - last_rise);
    meas_high   = int'(last_fall - last_rise);
    last_rise   = $time;
    rise_cnt++;
  end

  always @(negedge clko) begin
    if (mon_en) check("clko_min_high", 32'(($time - last_rise) >= 5), 32'd1);
    last_fall = $time;
  end

  task automatic wait_rises(input int n);
    int start;
    int guard;
    start = rise_cnt;
    guard = 0;
    while ((rise_cnt - start) < n && guard < 1200) begin
      @(negedge clki);
      guard++;
    end
    if ((rise_cnt - start) < n) check("clko_rise_timeout", 32'(rise_cnt - start), 32'(n));
  endtask

  task automatic measure(input string tag, input int per, input int hi);
    wait_rises(3);
    check({tag, "_period"}, 32'(meas_period), 32'(per));
    check({tag, "_high"}, 32'(meas_high), 32'(hi));
  endtask

  task automatic set_divs(input logic [DW-1:0] v);
    @(negedge clki); #3;
    divs = v;
  endtask

  task automatic assert_reset();
    @(negedge clki); #1;
    rst_ = 1'b0;
    model_reset();
  endtask

  task automatic release_reset(input int cyc);
    repeat (cyc) @(negedge clki);
    #1 rst_ = 1'b1;
  endtask

  task automatic reset_literals();
    @(posedge clki); #2;
    check("rst_clko_high", 32'(clko), 32'd1);
    check("rst_plso", 32'(plso), 32'd1);
    @(negedge clki); #2;
    check("rst_clko_low", 32'(clko), 32'd0);
  endtask

  initial begin
    divs = 8'd3;
    #1 rst_ = 1'b0;
    model_reset();
    model_on = 1'b1;
    reset_literals();
    release_reset(2);
    mon_en = 1'b1;

    measure("div4", 40, 20);
    set_divs(8'd2); measure("div3", 30, 20);
    set_divs(8'd1); measure("div2", 20, 10);
    set_divs(8'd0); measure("div1", 10, 5);
    set_divs(8'd3); measure("div4b", 40, 20);

    // divs 3 -> 5 in the middle of a period
    wait_rises(1);
    repeat (2) @(negedge clki);
    #3 divs = 8'd5;
    wait_rises(1);
    check("chg_old_period", 32'(meas_period), 32'd40);
    check("chg_old_high", 32'(meas_high), 32'd20);
    wait_rises(1);
    check("chg_new_period", 32'(meas_period), 32'd60);
    check("chg_new_high", 32'(meas_high), 32'd30);

    // reset in the middle of a divide-by-8 period
    set_divs(8'd7);
    wait_rises(3);
    repeat (2) @(negedge clki);
    assert_reset();
    reset_literals();
    release_reset(2);
    measure("div8", 80, 40);

    for (int it = 0; it < 150; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        assert_reset();
        release_reset(int'($urandom_range(1, 4)));
      end else if (r < 85) begin
        set_divs(DW'($urandom_range(0, 9)));
      end else begin
        set_divs(DW'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(1, 20)) @(negedge clki);
    end

    repeat (4) @(negedge clki);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
